// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control / trace unit: command opcodes,
// halt causes and run-control FSM states.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_HALT      = 3'd1,
    CMD_RUN       = 3'd2,
    CMD_STEP      = 3'd3,
    CMD_SET_BP    = 3'd4,
    CMD_CLR_BP    = 3'd5,
    CMD_CLR_TRACE = 3'd6,
    CMD_RSVD      = 3'd7
  } dbg_cmd_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HALT = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/cpu_debug_ctrl_trace.sv
// Circular PC/instruction trace buffer. The PC is written at fetch commit,
// the instruction on the next advancing cycle, which completes the entry.
module dbg_trace_buf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            commit_i,
  input  logic            adv_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [XLEN-1:0] rd_inst_o,
  output logic [AW:0]     count_o
);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic            pending_q;
  logic            capture;
  logic [AW-1:0]   pc_wr_addr;
  logic [AW-1:0]   rd_addr;

  assign capture    = pending_q && adv_i;
  // A fetch in the same cycle as a capture belongs to the following entry.
  assign pc_wr_addr = capture ? wr_ptr_q + AW'(1) : wr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != (AW+1)'(DEPTH)) count_q <= count_q + (AW+1)'(1);
      end
      if (clr_i) count_q <= '0;
      if (commit_i)   pending_q <= 1'b1;
      else if (adv_i) pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_i) pc_mem[pc_wr_addr] <= pc_i;
    if (capture)  inst_mem[wr_ptr_q] <= inst_i;
  end

  assign rd_addr   = wr_ptr_q - AW'(1) - rd_idx_i;
  assign rd_pc_o   = pc_mem[rd_addr];
  assign rd_inst_o = inst_mem[rd_addr];
  assign count_o   = count_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control unit for the multicycle core: halt/run/step FSM, PC breakpoints,
// retired-fetch counter and an instruction trace buffer.
module cpu_debug_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STATE_W      = 4,
  parameter int unsigned FETCH_STATE  = 0,
  parameter int unsigned NUM_BP       = 4,
  parameter int unsigned TRACE_DEPTH  = 16,
  parameter bit          RESET_HALTED = 1'b0,
  localparam int unsigned BP_IW       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int unsigned TR_AW       = $clog2(TRACE_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [BP_IW-1:0]   cmd_idx,
  input  logic [XLEN-1:0]    cmd_data,
  input  logic [STATE_W-1:0] core_state,
  input  logic [XLEN-1:0]    core_pc,
  input  logic [XLEN-1:0]    core_inst,
  output logic               core_en,
  output logic               halted,
  output logic [1:0]         halt_cause,
  input  logic [TR_AW-1:0]   trace_rd_idx,
  output logic [XLEN-1:0]    trace_pc,
  output logic [XLEN-1:0]    trace_inst,
  output logic [TR_AW:0]     trace_count,
  output logic [31:0]        retired
);

  dbg_state_e      state_q;
  halt_cause_e     cause_q;
  dbg_cmd_e        cmd;
  logic            halt_pending_q;
  logic            skip_bp_q;
  logic            step_fetched_q;
  logic [NUM_BP-1:0] bp_en_q;
  logic [XLEN-1:0] bp_addr_q [NUM_BP];
  logic [31:0]     retired_q;

  logic boundary, bp_hit, bp_match, stop_run, stop_step, fetch_commit, cmd_acc;

  assign cmd_ready = 1'b1;
  assign cmd_acc   = cmd_valid;
  always_comb cmd  = dbg_cmd_e'(cmd_op);

  assign boundary = (core_state == STATE_W'(FETCH_STATE));

  always_comb begin
    bp_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++)
      if (bp_en_q[i] && (bp_addr_q[i] == core_pc)) bp_hit = 1'b1;
  end

  assign bp_match  = boundary && !skip_bp_q && bp_hit;
  assign stop_run  = boundary && (bp_match || halt_pending_q);
  assign stop_step = boundary && step_fetched_q;

  always_comb begin
    core_en = 1'b0;
    unique case (state_q)
      ST_RUN:  core_en = !stop_run;
      ST_STEP: core_en = !stop_step;
      default: core_en = 1'b0;
    endcase
  end

  assign fetch_commit = boundary && core_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RESET_HALTED ? ST_HALTED : ST_RUN;
      cause_q        <= CAUSE_NONE;
      halt_pending_q <= 1'b0;
      skip_bp_q      <= 1'b0;
      step_fetched_q <= 1'b0;
      retired_q      <= '0;
    end else begin
      if (fetch_commit) begin
        retired_q <= retired_q + 32'd1;
        skip_bp_q <= 1'b0;
      end
      unique case (state_q)
        ST_RUN: begin
          if (stop_run) begin
            state_q        <= ST_HALTED;
            cause_q        <= bp_match ? CAUSE_BP : CAUSE_HALT;
            halt_pending_q <= 1'b0;
          end else if (cmd_acc && cmd == CMD_HALT) begin
            halt_pending_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (cmd_acc && cmd == CMD_RUN) begin
            state_q   <= ST_RUN;
            skip_bp_q <= 1'b1;
          end else if (cmd_acc && cmd == CMD_STEP) begin
            state_q        <= ST_STEP;
            skip_bp_q      <= 1'b1;
            step_fetched_q <= 1'b0;
          end
        end
        ST_STEP: begin
          if (stop_step) begin
            state_q <= ST_HALTED;
            cause_q <= bp_match ? CAUSE_BP : CAUSE_STEP;
          end else if (fetch_commit) begin
            step_fetched_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Addresses are left unreset; a comparator only fires when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_en_q <= '0;
    end else if (cmd_acc && (32'(cmd_idx) < NUM_BP)) begin
      if (cmd == CMD_SET_BP) begin
        bp_en_q[cmd_idx]   <= 1'b1;
        bp_addr_q[cmd_idx] <= cmd_data;
      end else if (cmd == CMD_CLR_BP) begin
        bp_en_q[cmd_idx] <= 1'b0;
      end
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign retired    = retired_q;

  dbg_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (cmd_acc && cmd == CMD_CLR_TRACE),
    .commit_i  (fetch_commit),
    .adv_i     (core_en),
    .pc_i      (core_pc),
    .inst_i    (core_inst),
    .rd_idx_i  (trace_rd_idx),
    .rd_pc_o   (trace_pc),
    .rd_inst_o (trace_inst),
    .count_o   (trace_count)
  );

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl driving a three-state core model
// (fetch, exec, writeback) that advances only when core_en is high.
module tb_cpu_debug_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned NUM_BP = 4;
  localparam int unsigned TRACE_DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_op = 3'd0;
  logic [1:0]         cmd_idx = 2'd0;
  logic [XLEN-1:0]    cmd_data = '0;
  logic [STATE_W-1:0] core_state = '0;
  logic [XLEN-1:0]    core_pc = '0;
  logic [XLEN-1:0]    core_inst = '0;
  logic               core_en;
  logic               halted;
  logic [1:0]         halt_cause;
  logic [1:0]         trace_rd_idx = 2'd0;
  logic [XLEN-1:0]    trace_pc;
  logic [XLEN-1:0]    trace_inst;
  logic [2:0]         trace_count;
  logic [31:0]        retired;

  int checks = 0;
  int errors = 0;

  cpu_debug_ctrl #(
    .XLEN         (XLEN),
    .STATE_W      (STATE_W),
    .FETCH_STATE  (0),
    .NUM_BP       (NUM_BP),
    .TRACE_DEPTH  (TRACE_DEPTH),
    .RESET_HALTED (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_idx      (cmd_idx),
    .cmd_data     (cmd_data),
    .core_state   (core_state),
    .core_pc      (core_pc),
    .core_inst    (core_inst),
    .core_en      (core_en),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .trace_rd_idx (trace_rd_idx),
    .trace_pc     (trace_pc),
    .trace_inst   (trace_inst),
    .trace_count  (trace_count),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; the core model advances if core_en was high before the edge.
  task automatic step();
    logic en;
    en = core_en;
    @(posedge clk);
    #1;
    if (en === 1'b1 && !reset) begin
      case (core_state)
        4'd0: begin
          core_inst  = 32'hC000_0000 | core_pc;
          core_state = 4'd1;
        end
        4'd1: core_state = 4'd2;
        default: begin
          core_state = 4'd0;
          core_pc    = core_pc + 32'd4;
        end
      endcase
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic run_to_pc(input logic [31:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (core_state == 4'd0 && core_pc == target) found = 1'b1;
      else step();
    end
    check("run_to_pc_reached", 32'(found), 32'd1);
  endtask

  task automatic wait_halt();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (halted) found = 1'b1;
      else step();
    end
    check("wait_halt_reached", 32'(found), 32'd1);
  endtask

  task automatic read_trace(input logic [1:0] idx, input logic [31:0] exp_pc, input string tag);
    trace_rd_idx = idx;
    #1;
    check(tag, trace_pc, exp_pc);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    core_state = '0;
    core_pc    = '0;
    core_inst  = '0;
    steps(2);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Test 1: reset state and free-running fetches at 0,4,8
    do_reset();
    check("rst_core_en", 32'(core_en), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_count", 32'(trace_count), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    steps(8);
    check("t1_retired", retired, 32'd3);
    check("t1_count", 32'(trace_count), 32'd3);
    read_trace(2'd0, 32'h8, "t1_trace_pc0");
    check("t1_trace_inst0", trace_inst, 32'hC000_0008);
    read_trace(2'd2, 32'h0, "t1_trace_pc2");

    // Test 2: breakpoint at 0x10, then resume past it
    cmd(3'd4, 2'd0, 32'h10);
    run_to_pc(32'h10);
    check("t2_bp_core_en", 32'(core_en), 32'd0);
    step();
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_cause", 32'(halt_cause), 32'd2);
    check("t2_retired", retired, 32'd4);
    cmd(3'd2, 2'd0, 32'h0);
    check("t2_resume_en", 32'(core_en), 32'd1);
    check("t2_resume_halted", 32'(halted), 32'd0);
    steps(3);
    check("t2_no_rehalt", 32'(halted), 32'd0);
    check("t2_retired_after", retired, 32'd5);

    // Test 3: halt at 0x20, single step to 0x24
    cmd(3'd4, 2'd1, 32'h20);
    run_to_pc(32'h20);
    step();
    check("t3_halt_bp", 32'(halt_cause), 32'd2);
    check("t3_retired_pre", retired, 32'd8);
    cmd(3'd3, 2'd0, 32'h0);
    check("t3_step_en", 32'(core_en), 32'd1);
    wait_halt();
    check("t3_cause", 32'(halt_cause), 32'd3);
    check("t3_retired", retired, 32'd9);
    check("t3_stop_pc", core_pc, 32'h24);

    // Test 4: HALT mid-instruction waits for the fetch boundary
    cmd(3'd2, 2'd0, 32'h0);
    step();
    cmd(3'd1, 2'd0, 32'h0);
    check("t4_nonfetch_en", 32'(core_en), 32'd1);
    step();
    check("t4_boundary_en", 32'(core_en), 32'd0);
    check("t4_not_yet_halted", 32'(halted), 32'd0);
    step();
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_cause", 32'(halt_cause), 32'd1);
    check("t4_retired", retired, 32'd10);
    // HALT and breakpoint on the same boundary: breakpoint wins
    cmd(3'd4, 2'd2, 32'h2C);
    cmd(3'd2, 2'd0, 32'h0);
    step();
    cmd(3'd1, 2'd0, 32'h0);
    step();
    check("t4_tie_en", 32'(core_en), 32'd0);
    step();
    check("t4_tie_cause", 32'(halt_cause), 32'd2);
    check("t4_tie_retired", retired, 32'd11);
    cmd(3'd2, 2'd0, 32'h0);
    steps(4);
    check("t4_pending_cleared", 32'(halted), 32'd0);
    check("t4_retired_after", retired, 32'd13);

    // Test 5: trace wrap with depth 4, then CLR_TRACE
    do_reset();
    steps(17);
    check("t5_retired", retired, 32'd6);
    check("t5_count_sat", 32'(trace_count), 32'd4);
    read_trace(2'd0, 32'h14, "t5_trace_pc0");
    check("t5_trace_inst0", trace_inst, 32'hC000_0014);
    read_trace(2'd1, 32'h10, "t5_trace_pc1");
    read_trace(2'd3, 32'h8, "t5_trace_pc3");
    cmd(3'd6, 2'd0, 32'h0);
    check("t5_clr_count", 32'(trace_count), 32'd0);
    check("t5_clr_retired", retired, 32'd6);
    steps(2);
    check("t5_count_after_clr", 32'(trace_count), 32'd1);
    read_trace(2'd0, 32'h18, "t5_trace_after_clr");

    // Test 6: reset during STEP with an instruction capture pending
    cmd(3'd1, 2'd0, 32'h0);
    step();
    check("t6_halted", 32'(halted), 32'd1);
    cmd(3'd4, 2'd3, 32'h20);
    cmd(3'd3, 2'd0, 32'h0);
    step();
    check("t6_pending_count", 32'(trace_count), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t6_rst_halted", 32'(halted), 32'd0);
    check("t6_rst_cause", 32'(halt_cause), 32'd0);
    check("t6_rst_count", 32'(trace_count), 32'd0);
    check("t6_rst_retired", retired, 32'd0);
    steps(2);
    check("t6_bp_disabled_en", 32'(core_en), 32'd1);
    steps(2);
    check("t6_count", 32'(trace_count), 32'd1);
    read_trace(2'd0, 32'h20, "t6_trace_pc0");
    check("t6_trace_inst0", trace_inst, 32'hC000_0020);
    check("t6_retired", retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
